riscv_if_prefetch: RTL and testbench
====================================

// Module: riscv_if_prefetch
// PURPOSE
//  RV32IC instruction fetch stage with a parametrised 16-bit parcel prefetch queue. Fetches aligned
//  32-bit words from ICACHE ahead of decode, realigns 16/32-bit instructions across word boundaries,
//  and loads the IF/ID pipeline register. Redirects (jal/jalr/branch) flush the queue and cancel
//  in-flight fetches. Sits between the PC-redirect logic of EX and the ID stage.
// PARAMETERS
//  QDEPTH    8   queue capacity in 16-bit parcels; power of 2, >= 4
//  RESET_PC  0   PC after reset; bit 0 must be 0
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  stall            in   1   hold IF/ID regs and decode PC
//  load_use_hazard  in   1   no issue this cycle; IF/ID loads a bubble
//  flush            in   1   IF/ID loads a bubble; queue kept
//  redirect_valid   in   1   taken jal/jalr/branch
//  redirect_pc      in   32  redirect target (bit 0 ignored)
//  ICACHE_stall     in   1   cache busy; rdata valid when ren=1 and ICACHE_stall=0
//  ICACHE_ren       out  1   read request
//  ICACHE_wen       out  1   constant 0
//  ICACHE_addr      out  30  word address (fpc[31:2])
//  ICACHE_rdata     in   32  little-endian word; [15:0] = lower parcel
//  ICACHE_wdata     out  32  constant 0
//  inst_ppl         out  32  IF/ID instruction (compressed: {16'b0,parcel})
//  pc_ppl           out  32  IF/ID PC
//  compressed_ppl   out  1   IF/ID instruction is 16-bit
//  valid_ppl        out  1   IF/ID holds a real instruction
//  PC               out  32  decode PC (PC of next instruction to issue)
// BEHAVIOUR
//  Reset: PC=RESET_PC, fpc=RESET_PC&~3, queue empty, skip=RESET_PC[1], drop=0; inst_ppl=32'h13,
//   pc_ppl=0, compressed_ppl=0, valid_ppl=0; ICACHE_ren=0 in every cycle rst=1.
//  Fetch: ICACHE_ren=1 when drop=1, or when free parcels (QDEPTH-count, registered) >= 2; addr
//   held stable while ICACHE_stall=1. On ren&!ICACHE_stall: push lower then upper parcel (upper only
//   if skip=1, then skip<=0), fpc+=4. No credit for same-cycle pops. No push ever overflows.
//  Head decode: head[1:0]!=2'b11 -> 16-bit, needs count>=1; else 32-bit, needs count>=2,
//   inst={parcel1,parcel0}. Ready = required parcels present (same-cycle pushes not visible).
//  Issue (redirect_valid=0, stall=0, load_use_hazard=0, flush=0, ready): IF/ID <= {inst,PC,
//   compressed,1}; pop 1 or 2; PC+=2 or 4. Otherwise with stall=0: IF/ID <= {32'h13,PC,0,0}, no pop.
//  stall=1: IF/ID and PC held (unless redirect); fetching continues while space remains.
//  Redirect (highest priority for PC/queue): queue cleared (pointers reset), PC<=redirect_pc&~1,
//   fpc<=redirect_pc&~3, skip<=redirect_pc[1]; IF/ID gets bubble if stall=0, held if stall=1.
//   If a request is stalled in flight (ren=1, ICACHE_stall=1), drop<=1: request kept until
//   ICACHE_stall=0, data discarded, fpc not advanced; next request uses new fpc. A same-cycle
//   completing fetch is discarded. Redirect during drop=1 only updates PC/fpc/skip.
//  Queue: circular, rd/wr pointers mod QDEPTH, count 0..QDEPTH; push+pop same cycle allowed.
//  PC arithmetic 32-bit, wraps at 2^32 silently.
//  rst mid-fetch: state reset immediately; outstanding cache response ignored.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (completed accepted fetches),
//   perf_bubble_cnt[31:0] (cycles stall=0 and valid not loaded), perf_redirect_cnt[31:0]
//   (redirect_valid cycles); all reset to 0, wrap at 2^32. Undefined: ports and logic absent,
//   otherwise identical behaviour.
// TESTING
//  Reset, cache zero-latency, words 0x00000013,0x00A00093 -> valid_ppl first at cycle 3,
//   pc_ppl 0,4,8 consecutive, compressed_ppl=0.
//  Word@0 = 0x00934501 (c.li a0,0 then low half of 32-bit), word@4 = 0x....0533 -> issue
//   16-bit @0 (inst 0x4501), then 32-bit @2 spanning words, PC=6 after.
//  Redirect to 0x102 while ICACHE_stall=1 for 3 cycles -> stale word discarded, next ICACHE_addr
//   =0x40, lower parcel skipped, first valid pc_ppl=0x102.
//  stall=1 for 10 cycles, QDEPTH=8 -> ICACHE_ren drops when count>6; IF/ID unchanged; resumes
//   issuing in order after release with no lost parcel.
//  load_use_hazard=1 one cycle -> one bubble (inst 0x13, valid 0), same pc_ppl issued next cycle;
//   flush=1 with redirect_valid=0 -> bubble, queue preserved.

Source files
------------

// File: rtl/riscv_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : riscv_if_prefetch
// Brief    : RV32IC fetch stage with a 16-bit parcel prefetch queue feeding IF/ID.
//            Optional performance counters enabled by defining IF_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module riscv_if_prefetch #(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        load_use_hazard,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ICACHE_stall,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    output logic [31:0] ICACHE_wdata,
    output logic [31:0] inst_ppl,
    output logic [31:0] pc_ppl,
    output logic        compressed_ppl,
    output logic        valid_ppl,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_redirect_cnt,
`endif
    output logic [31:0] PC
);

    localparam int          PW       = $clog2(QDEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(QDEPTH);
    localparam logic [31:0] C_NOP    = 32'h0000_0013;

    logic [15:0]    r_q [QDEPTH];
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_pc;
    logic [31:0]    r_fpc;
    logic           r_skip;
    logic           r_drop;
    logic [29:0]    r_drop_addr;
    logic [31:0]    r_inst;
    logic [31:0]    r_pc_ppl;
    logic           r_comp;
    logic           r_valid;

    logic [CW-1:0]  w_free;
    logic           w_ren;
    logic           w_push;
    logic [1:0]     w_push_n;
    logic [15:0]    w_p0;
    logic [15:0]    w_p1;
    logic           w_is32;
    logic           w_ready;
    logic           w_issue;
    logic [1:0]     w_pop_n;

    assign w_free   = C_DEPTH - r_count;
    // While a discarded request is outstanding the request line must stay up.
    assign w_ren    = !rst && (r_drop || (w_free >= CW'(2)));
    assign w_push   = w_ren && !ICACHE_stall && !r_drop && !redirect_valid;
    assign w_push_n = w_push ? (r_skip ? 2'd1 : 2'd2) : 2'd0;

    assign w_p0     = r_q[r_rd];
    assign w_p1     = r_q[r_rd + PW'(1)];
    assign w_is32   = (w_p0[1:0] == 2'b11);
    assign w_ready  = w_is32 ? (r_count >= CW'(2)) : (r_count >= CW'(1));
    assign w_issue  = !redirect_valid && !stall && !load_use_hazard && !flush && w_ready;
    assign w_pop_n  = w_issue ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;

    assign ICACHE_ren     = w_ren;
    assign ICACHE_wen     = 1'b0;
    assign ICACHE_wdata   = 32'h0;
    assign ICACHE_addr    = r_drop ? r_drop_addr : r_fpc[31:2];
    assign inst_ppl       = r_inst;
    assign pc_ppl         = r_pc_ppl;
    assign compressed_ppl = r_comp;
    assign valid_ppl      = r_valid;
    assign PC             = r_pc;

    // Parcel storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (r_skip) begin
                r_q[r_wr] <= ICACHE_rdata[31:16];
            end else begin
                r_q[r_wr]          <= ICACHE_rdata[15:0];
                r_q[r_wr + PW'(1)] <= ICACHE_rdata[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_pc        <= RESET_PC;
            r_fpc       <= {RESET_PC[31:2], 2'b00};
            r_skip      <= RESET_PC[1];
            r_drop      <= 1'b0;
            r_drop_addr <= '0;
            r_inst      <= C_NOP;
            r_pc_ppl    <= 32'h0;
            r_comp      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (r_drop) begin
                if (!ICACHE_stall) begin
                    r_drop <= 1'b0;
                end
            end else if (redirect_valid && w_ren && ICACHE_stall) begin
                r_drop      <= 1'b1;
                r_drop_addr <= r_fpc[31:2];
            end

            if (redirect_valid) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_pc    <= {redirect_pc[31:1], 1'b0};
                r_fpc   <= {redirect_pc[31:2], 2'b00};
                r_skip  <= redirect_pc[1];
            end else begin
                r_rd    <= r_rd + PW'(w_pop_n);
                r_wr    <= r_wr + PW'(w_push_n);
                r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
                if (w_push) begin
                    r_fpc  <= r_fpc + 32'd4;
                    r_skip <= 1'b0;
                end
                if (w_issue) begin
                    r_pc <= r_pc + (w_is32 ? 32'd4 : 32'd2);
                end
            end

            if (!stall) begin
                r_pc_ppl <= r_pc;
                if (w_issue) begin
                    r_inst  <= w_is32 ? {w_p1, w_p0} : {16'h0, w_p0};
                    r_comp  <= !w_is32;
                    r_valid <= 1'b1;
                end else begin
                    r_inst  <= C_NOP;
                    r_comp  <= 1'b0;
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch    <= 32'h0;
            r_perf_bubble   <= 32'h0;
            r_perf_redirect <= 32'h0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (!stall && !w_issue) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
            if (redirect_valid) begin
                r_perf_redirect <= r_perf_redirect + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = r_perf_fetch;
    assign perf_bubble_cnt   = r_perf_bubble;
    assign perf_redirect_cnt = r_perf_redirect;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_if_prefetch
// Brief    : Self-checking bench: program-order model of issued instructions.
// Revision : 1.0
// ============================================================================
module tb_riscv_if_prefetch;

    localparam int          C_STARVE = 60;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        load_use_hazard = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ICACHE_stall = 1'b0;
    logic        ICACHE_ren;
    logic        ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] ICACHE_wdata;
    logic [31:0] inst_ppl;
    logic [31:0] pc_ppl;
    logic        compressed_ppl;
    logic        valid_ppl;
    logic [31:0] PC;

    logic [31:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc = 32'h0;
    int          idle = 0;

    always #5 clk = ~clk;

    assign ICACHE_rdata = mem[ICACHE_addr[7:0]];

    riscv_if_prefetch #(.QDEPTH(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .load_use_hazard(load_use_hazard),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ICACHE_stall(ICACHE_stall), .ICACHE_ren(ICACHE_ren), .ICACHE_wen(ICACHE_wen),
        .ICACHE_addr(ICACHE_addr), .ICACHE_rdata(ICACHE_rdata), .ICACHE_wdata(ICACHE_wdata),
        .inst_ppl(inst_ppl), .pc_ppl(pc_ppl), .compressed_ppl(compressed_ppl),
        .valid_ppl(valid_ppl), .PC(PC)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Architectural view: instruction at a byte address, as a program would see it.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        logic [15:0] p0;
        p0 = half(a);
        return (p0[1:0] == 2'b11) ? {half(a + 32'd2), p0} : {16'h0, p0};
    endfunction

    task automatic expect_bubble(input string tag);
        chk({tag, "_valid"}, valid_ppl, 0);
        chk({tag, "_inst"}, inst_ppl, C_NOP);
        chk({tag, "_pc"}, pc_ppl, exp_pc);
        chk({tag, "_comp"}, compressed_ppl, 0);
    endtask

    task automatic step();
        logic p_rst, p_stall, p_ctl, p_rv, p_ren, p_ics, p_valid, p_comp;
        logic [31:0] p_rpc, p_inst, p_pcp, e_inst;
        logic [29:0] p_addr;
        p_rst = rst; p_stall = stall; p_rv = redirect_valid; p_rpc = redirect_pc;
        p_ctl = redirect_valid | load_use_hazard | flush;
        p_ren = ICACHE_ren; p_ics = ICACHE_stall; p_addr = ICACHE_addr;
        p_inst = inst_ppl; p_pcp = pc_ppl; p_valid = valid_ppl; p_comp = compressed_ppl;
        @(posedge clk);
        #1;
        if (p_rst) begin
            exp_pc = 32'h0;
            idle = 0;
            chk("rst_valid", valid_ppl, 0);
            chk("rst_inst", inst_ppl, C_NOP);
            chk("rst_pcppl", pc_ppl, 0);
            chk("rst_comp", compressed_ppl, 0);
            chk("rst_PC", PC, 0);
            if (rst) chk("rst_ren", ICACHE_ren, 0);
        end else begin
            if (p_stall) begin
                chk("hold_inst", inst_ppl, p_inst);
                chk("hold_pc", pc_ppl, p_pcp);
                chk("hold_flags", {valid_ppl, compressed_ppl}, {p_valid, p_comp});
            end else if (p_ctl) begin
                expect_bubble("ctl");
            end else if (valid_ppl) begin
                e_inst = inst_at(exp_pc);
                chk("issue_pc", pc_ppl, exp_pc);
                chk("issue_inst", inst_ppl, e_inst);
                chk("issue_comp", compressed_ppl, e_inst[1:0] != 2'b11);
                exp_pc = exp_pc + ((e_inst[1:0] == 2'b11) ? 32'd4 : 32'd2);
                idle = 0;
            end else begin
                expect_bubble("idle");
                idle++;
                if (idle > C_STARVE) begin
                    chk("starve", idle, C_STARVE);
                    idle = 0;
                end
            end
            if (p_rv) begin
                exp_pc = {p_rpc[31:1], 1'b0};
                idle = 0;
            end
            chk("PC", PC, exp_pc);
            if (p_ren && p_ics && !rst) begin
                chk("ren_hold", ICACHE_ren, 1);
                chk("addr_hold", ICACHE_addr, p_addr);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 0; load_use_hazard = 0; flush = 0; redirect_valid = 0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        // Zero-latency cache, plain 32-bit program.
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 32'h0000_0013 : 32'h00A0_0093;
        ICACHE_stall = 0;
        do_reset();
        step(); chk("first_E1_valid", valid_ppl, 0);
        step(); chk("first_E2_valid", valid_ppl, 1); chk("first_pc", pc_ppl, 32'h0);
        step(); chk("second_pc", pc_ppl, 32'h4);
        step(); chk("third_pc", pc_ppl, 32'h8); chk("third_comp", compressed_ppl, 0);

        // 16-bit instruction followed by a 32-bit one spanning a word boundary.
        mem[0] = 32'h0093_4501; mem[1] = 32'h0000_0533;
        do_reset();
        step(); step();
        chk("c_inst", inst_ppl, 32'h0000_4501); chk("c_comp", compressed_ppl, 1);
        step();
        chk("span_inst", inst_ppl, 32'h0533_0093); chk("span_pc", pc_ppl, 32'h2);
        chk("span_PC", PC, 32'h6);

        // Redirect while the first fetch is stalled in the cache.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        ICACHE_stall = 1;
        do_reset();
        step();
        redirect_valid = 1; redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 0;
        step();
        ICACHE_stall = 0;
        step();
        chk("redir_addr", ICACHE_addr, 30'h40);
        chk("redir_ren", ICACHE_ren, 1);
        k = 0;
        while (!valid_ppl && k < 10) begin step(); k++; end
        chk("redir_first_pc", pc_ppl, 32'h102);
        for (int i = 0; i < 4; i++) step();

        // Long decode stall: fetch must stop once the queue is full.
        stall = 1;
        for (int i = 0; i < 10; i++) step();
        chk("full_ren", ICACHE_ren, 0);
        stall = 0;
        for (int i = 0; i < 6; i++) step();

        // Single-cycle load-use hazard, then a flush.
        load_use_hazard = 1; step(); load_use_hazard = 0;
        chk("luh_bubble", valid_ppl, 0);
        step(); step();
        flush = 1; step(); flush = 0;
        chk("flush_bubble", valid_ppl, 0);
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom % 600) == 0;
            stall           = ($urandom % 100) < 15;
            load_use_hazard = ($urandom % 100) < 5;
            flush           = ($urandom % 100) < 4;
            redirect_valid  = ($urandom % 100) < 4;
            redirect_pc     = (($urandom % 4) == 0) ? $urandom : ($urandom % 1024);
            ICACHE_stall    = ($urandom % 100) < 30;
            step();
        end
        rst = 0; stall = 0; load_use_hazard = 0; flush = 0; redirect_valid = 0;
        ICACHE_stall = 0;
        for (int i = 0; i < 8; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
